// File: rtl/multi_chan_fifo.sv
// Multi-channel FIFO: CHANNELS circular queues sharing one storage array,
// with registered read data, per-channel flush, status vectors and sticky error flags.
module multi_chan_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CHANNELS = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [$clog2(CHANNELS)-1:0] i_wr_ch,
    input  logic [WIDTH-1:0]            i_wr_data,
    input  logic                        i_rd_en,
    input  logic [$clog2(CHANNELS)-1:0] i_rd_ch,
    output logic [WIDTH-1:0]            o_rd_data,
    output logic                        o_rd_valid,
    input  logic                        i_flush_en,
    input  logic [$clog2(CHANNELS)-1:0] i_flush_ch,
    output logic [CHANNELS-1:0]         o_empty,
    output logic [CHANNELS-1:0]         o_full,
    output logic [CHANNELS-1:0]         o_overflow,
    output logic [CHANNELS-1:0]         o_underflow,
    input  logic                        i_err_clr
);

    localparam int unsigned CW = $clog2(CHANNELS);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned NW = CHANNELS * DEPTH;

    logic [PW-1:0]       r_wr_ptr [CHANNELS];
    logic [PW-1:0]       r_rd_ptr [CHANNELS];
    logic [WIDTH-1:0]    r_mem    [NW];
    logic [WIDTH-1:0]    r_rd_data;
    logic                r_rd_valid;
    logic [CHANNELS-1:0] r_overflow;
    logic [CHANNELS-1:0] r_underflow;

    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_ovf_set;
    logic [CHANNELS-1:0] w_udf_set;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_rd_flushed;
    logic [CW+AW-1:0]    w_wr_addr;
    logic [CW+AW-1:0]    w_rd_addr;

    // Per-channel status; the wrap bit distinguishes full from empty
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
            w_full[c]  = (r_wr_ptr[c][AW-1:0] == r_rd_ptr[c][AW-1:0]) &&
                         (r_wr_ptr[c][AW] != r_rd_ptr[c][AW]);
        end
    end

    // Request acceptance, judged on pre-edge pointer state
    always_comb begin
        w_ovf_set    = '0;
        w_udf_set    = '0;
        w_rd_flushed = i_flush_en && (i_flush_ch == i_rd_ch);
        w_wr_acc     = i_wr_en && !w_full[i_wr_ch];
        w_rd_acc     = i_rd_en && !w_empty[i_rd_ch] && !w_rd_flushed;
        if (i_wr_en && w_full[i_wr_ch]) begin
            w_ovf_set[i_wr_ch] = 1'b1;
        end
        if (i_rd_en && w_empty[i_rd_ch]) begin
            w_udf_set[i_rd_ch] = 1'b1;
        end
        w_wr_addr = {i_wr_ch, r_wr_ptr[i_wr_ch][AW-1:0]};
        w_rd_addr = {i_rd_ch, r_rd_ptr[i_rd_ch][AW-1:0]};
    end

    // Pointers: a flush snaps rd_ptr to the pre-edge wr_ptr, so a same-cycle write survives
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (w_wr_acc && (i_wr_ch == CW'(c))) begin
                    r_wr_ptr[c] <= r_wr_ptr[c] + PW'(1);
                end
                if (i_flush_en && (i_flush_ch == CW'(c))) begin
                    r_rd_ptr[c] <= r_wr_ptr[c];
                end else if (w_rd_acc && (i_rd_ch == CW'(c))) begin
                    r_rd_ptr[c] <= r_rd_ptr[c] + PW'(1);
                end
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_acc) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

    // Sticky errors: a new error in the clearing cycle keeps its bit set
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= '0;
            r_underflow <= '0;
        end else begin
            r_overflow  <= (i_err_clr ? '0 : r_overflow)  | w_ovf_set;
            r_underflow <= (i_err_clr ? '0 : r_underflow) | w_udf_set;
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Scoreboard bench for multi_chan_fifo: directed stimulus pushes expected read words,
// a negedge monitor checks rd_valid timing and pops/compares rd_data.
module tb_multi_chan_fifo;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 16;
    localparam int unsigned C  = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [CW-1:0] rd_ch = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          flush_en = 1'b0;
    logic [CW-1:0] flush_ch = '0;
    logic [C-1:0]  empty;
    logic [C-1:0]  full;
    logic [C-1:0]  overflow;
    logic [C-1:0]  underflow;
    logic          err_clr = 1'b0;

    logic [W-1:0]  exp_q[$];
    logic          rd_expect = 1'b0;
    logic          exp_vld = 1'b0;
    logic [W-1:0]  exp_word;
    int            errors = 0;
    int            checks = 0;

    multi_chan_fifo #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_ch     (wr_ch),
        .i_wr_data   (wr_data),
        .i_rd_en     (rd_en),
        .i_rd_ch     (rd_ch),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .i_flush_en  (flush_en),
        .i_flush_ch  (flush_ch),
        .o_empty     (empty),
        .o_full      (full),
        .o_overflow  (overflow),
        .o_underflow (underflow),
        .i_err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Expected rd_valid: one cycle after a read the stimulus marked as accepted
    always @(posedge clk) exp_vld <= rd_expect && !rst;

    always @(negedge clk) begin
        checks++;
        if (rd_valid !== exp_vld) begin
            errors++;
            $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, exp_vld, $time);
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: unexpected word %h at %0t", rd_data, $time);
            end else begin
                exp_word = exp_q.pop_front();
                if (rd_data !== exp_word) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h at %0t", rd_data, exp_word, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        flush_en  = 1'b0;
        err_clr   = 1'b0;
        rd_expect = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = CW'(ch);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [W-1:0] d);
        rd_en     = 1'b1;
        rd_ch     = CW'(ch);
        rd_expect = 1'b1;
        exp_q.push_back(d);
        tick();
        rd_en     = 1'b0;
        rd_expect = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        idle();
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_empty", 64'(empty), 64'hFFFF);
        chk("reset_full", 64'(full), 64'h0);
        chk("reset_ovf", 64'(overflow), 64'h0);
        chk("reset_udf", 64'(underflow), 64'h0);
        chk("reset_rd_data", 64'(rd_data), 64'h0);

        // Fill ch 3, overflow it, drain back-to-back
        for (int k = 0; k < 16; k++) begin
            wr(3, W'(32'hA0 + k));
            if (k == 14) chk("ch3_not_full_15", 64'(full), 64'h0);
        end
        chk("ch3_full", 64'(full), 64'h0008);
        chk("ch3_empty_vec", 64'(empty), 64'hFFF7);
        wr(3, W'(32'hEE));
        chk("ch3_overflow", 64'(overflow), 64'h0008);
        chk("ch3_full_kept", 64'(full), 64'h0008);
        for (int k = 0; k < 16; k++) rd(3, W'(32'hA0 + k));
        chk("ch3_drained", 64'(empty), 64'hFFFF);
        err_clr = 1'b1;
        tick();
        idle();
        chk("err_clr_ovf", 64'(overflow), 64'h0);

        // Interleaved channels 0 and 15
        for (int k = 0; k < 5; k++) begin
            wr(0, W'(32'h100 + k));
            wr(15, W'(32'h200 + k));
        end
        chk("ch0_15_empty_vec", 64'(empty), 64'h7FFE);
        for (int k = 0; k < 5; k++) begin
            rd(0, W'(32'h100 + k));
            rd(15, W'(32'h200 + k));
        end
        chk("ch0_15_drained", 64'(empty), 64'hFFFF);

        // Pointer wrap on ch 2: 4 rounds of 10
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 10; k++) wr(2, W'(32'h300 + r * 16 + k));
            chk("ch2_never_full", 64'(full), 64'h0);
            for (int k = 0; k < 10; k++) rd(2, W'(32'h300 + r * 16 + k));
        end
        chk("ch2_wrap_empty", 64'(empty), 64'hFFFF);
        chk("ch2_wrap_ovf", 64'(overflow), 64'h0);
        chk("ch2_wrap_udf", 64'(underflow), 64'h0);

        // Full ch 7: same-cycle write+read, write dropped
        for (int k = 0; k < 16; k++) wr(7, W'(32'h700 + k));
        chk("ch7_full", 64'(full), 64'h0080);
        wr_en = 1'b1; wr_ch = 4'd7; wr_data = W'(32'h55);
        rd_en = 1'b1; rd_ch = 4'd7; rd_expect = 1'b1;
        exp_q.push_back(W'(32'h700));
        tick();
        idle();
        chk("ch7_overflow", 64'(overflow), 64'h0080);
        chk("ch7_not_full", 64'(full), 64'h0);
        err_clr = 1'b1; rd_en = 1'b1; rd_ch = 4'd9;
        tick();
        idle();
        chk("clr_ovf7", 64'(overflow), 64'h0);
        chk("udf9_wins", 64'(underflow), 64'h0200);
        for (int k = 1; k < 16; k++) rd(7, W'(32'h700 + k));
        chk("ch7_drained", 64'(empty), 64'hFFFF);
        err_clr = 1'b1;
        tick();
        idle();
        chk("clr_udf", 64'(underflow), 64'h0);

        // Flush + write on ch 4
        for (int k = 0; k < 3; k++) wr(4, W'(32'h40 + k));
        flush_en = 1'b1; flush_ch = 4'd4;
        wr_en = 1'b1; wr_ch = 4'd4; wr_data = W'(32'h77);
        tick();
        idle();
        chk("ch4_flush_wr_occ1", 64'(empty), 64'hFFEF);
        rd(4, W'(32'h77));
        chk("ch4_empty_after", 64'(empty), 64'hFFFF);

        // Flush + read on ch 5: read dropped, no flag
        wr(5, W'(32'h51));
        flush_en = 1'b1; flush_ch = 4'd5;
        rd_en = 1'b1; rd_ch = 4'd5;
        tick();
        idle();
        chk("ch5_no_udf", 64'(underflow), 64'h0);
        chk("ch5_flushed", 64'(empty), 64'hFFFF);

        // No write-to-read bypass on ch 6
        wr_en = 1'b1; wr_ch = 4'd6; wr_data = W'(32'h66);
        rd_en = 1'b1; rd_ch = 4'd6;
        tick();
        idle();
        chk("ch6_udf", 64'(underflow), 64'h0040);
        chk("ch6_written", 64'(empty), 64'hFFBF);
        rd(6, W'(32'h66));
        err_clr = 1'b1;
        tick();
        idle();

        // Reset mid-operation
        wr(1, W'(32'h11));
        wr(1, W'(32'h12));
        wr(1, W'(32'h13));
        rd_en = 1'b1; rd_ch = 4'd8;
        tick();
        idle();
        chk("ch8_udf", 64'(underflow), 64'h0100);
        rd(1, W'(32'h11));
        rst = 1'b1;
        rd_en = 1'b1; rd_ch = 4'd1;
        wr_en = 1'b1; wr_ch = 4'd3; wr_data = W'(32'h99);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_empty", 64'(empty), 64'hFFFF);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);
        chk("rst_udf", 64'(underflow), 64'h0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        rd_en = 1'b1; rd_ch = 4'd1;
        tick();
        idle();
        chk("post_rst_udf1", 64'(underflow), 64'h0002);

        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_chan_fifo.md
# multi_chan_fifo

Synthesizable multi-channel FIFO: CHANNELS independent circular queues of DEPTH words of WIDTH bits each, held in one shared storage array indexed by {channel, pointer}. It is the hardware successor to the behavioural per-channel test queue. It is used between the command decoder and the per-channel engines, and doubles as a bench scoreboard. It adds full-depth capacity, registered read data, per-channel flush, status vectors and sticky error flags instead of simulation stops.

## Interface
Parameters:
- WIDTH, 32, data word width
- DEPTH, 16, words per channel; power of two, >= 2
- CHANNELS, 16, number of queues; >= 2
- derived: CW = $clog2(CHANNELS), AW = $clog2(DEPTH)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write request
- wr_ch  in  CW  write channel
- wr_data  in  WIDTH  write word
- rd_en  in  1  read request
- rd_ch  in  CW  read channel
- rd_data  out  WIDTH  registered read word
- rd_valid  out  1  one-cycle pulse: rd_data holds the word of an accepted read
- flush_en  in  1  flush request
- flush_ch  in  CW  channel to flush
- empty  out  CHANNELS  bit i = queue i empty
- full  out  CHANNELS  bit i = queue i holds DEPTH words
- overflow  out  CHANNELS  sticky: write rejected on channel i
- underflow  out  CHANNELS  sticky: read rejected on channel i
- err_clr  in  1  clears both sticky vectors

## Operation
- Per channel: wr_ptr and rd_ptr, each AW+1 bits, with the MSB as the wrap bit. Occupancy = wr_ptr - rd_ptr (mod 2^(AW+1)), range 0..DEPTH.
- empty[i] = (wr_ptr == rd_ptr). full[i] = (low AW bits equal, MSBs differ). Both are combinational from the registered pointers only.
- Storage address = {ch, ptr[AW-1:0]}, CHANNELS*DEPTH words. Contents are not cleared by reset.
- Write accepted iff wr_en && !full[wr_ch], judged on pre-edge state:
  - stores wr_data and increments wr_ptr[wr_ch].
  - If rejected: the word is dropped and overflow[wr_ch] is set.
- Read accepted iff rd_en && !empty[rd_ch] && !(flush_en && flush_ch == rd_ch):
  - increments rd_ptr[rd_ch].
  - If rejected because the queue is empty: underflow[rd_ch] is set and there is no rd_valid.
  - If rejected because of a flush: no error flag is set.
- Flush: rd_ptr[flush_ch] <= wr_ptr[flush_ch] (pre-edge value). The queue becomes empty.
- Simultaneous events:
  - Read and write on the same channel: both honoured if each condition holds. There is no write-to-read bypass; a read of an empty queue is rejected even with a same-cycle write.
  - Write to a full queue with a same-cycle read of it: the write is rejected and the read is accepted.
  - Flush and write on the same channel: the write is accepted and survives, giving occupancy 1 afterwards.
  - Different channels are fully independent in the same cycle.
- Wrap-around: pointers roll over modulo 2^(AW+1). Storage index wraps modulo DEPTH.
- err_clr clears overflow and underflow. A new error in the same cycle wins, so that bit stays 1.

## Timing
- Write: stored at edge N. empty deasserts after edge N. The word is readable by a request in cycle N+1.
- Read latency 1: request accepted at edge N gives rd_data valid and rd_valid=1 during cycle N+1. Back-to-back reads sustain 1 word/cycle.
- rd_data holds its last value when rd_valid=0.
- full/empty update one edge after the causing request.
- Reset values: all pointers 0, empty = all ones, full = 0, rd_valid = 0, rd_data = 0, overflow = 0, underflow = 0.
- Reset mid-operation: a pending rd_valid is suppressed. All queues read as empty from the next cycle. Requests presented during rst are ignored and set no flags.

## Test plan
- Reset, then write 0xA0..0xAF to ch 3 (DEPTH=16) -> full[3]=1 after 16th edge; 17th write sets overflow[3]=1; reading 16 back returns 0xA0..0xAF in order with rd_valid one cycle after each request; empty[3]=1 after the last read.
- Interleave writes to ch 0 (0x100+k) and ch 15 (0x200+k), 5 each, then read alternately -> each channel returns its own sequence; no cross-talk; all other empty bits stay 1.
- Fill ch 2 with 10 words, read 10, repeat 4 times (exceeds 2*DEPTH) -> data order is correct across pointer wrap; full never asserts; no flags set.
- ch 7 full: same cycle wr 0x55 + rd -> read accepted, write rejected, overflow[7]=1. Then err_clr with a same-cycle empty read on ch 9 -> overflow[7]=0, underflow[9]=1.
- ch 4 holding 3 words: flush + write 0x77 same cycle -> next read returns 0x77, then empty[4]=1. Flush + read same cycle on ch 5 -> no rd_valid, underflow[5]=0.
- Assert rst in the cycle after a read request -> rd_valid=0, empty all ones, flags 0 next cycle.
